// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcodes, fetch FSM states, fetch queue entry.
// Pure declarations, no logic.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_JRSAL = 6'b010001;
    localparam logic [5:0] OP_BALN  = 6'b011001;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // FETCH: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_FETCH = 2'd0;
    localparam fetch_state_t ST_WAIT  = 2'd1;
    localparam fetch_state_t ST_DROP  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of {pc, instr}; head slot is always the output.
// Latency: push visible at head one cycle later, no bypass.
// Backpressure: head held while not popped; push while full without pop is ignored.
module fetch_queue
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    output logic [1:0]   count,
    output fetch_entry_t head_dat
);

    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok  = push && ((count_q != 2'd2) || pop);
    assign pop_ok   = pop && (count_q != 2'd0);
    assign count    = count_q;
    assign head_dat = e0_q;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) e0_d = push_dat;
                    else                 e1_d = push_dat;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_d = push_dat;
                    end else begin
                        e0_d = e1_q;
                        e1_d = push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem reads, 2-entry queue to decode.
// Latency: response to id_valid 1 cycle; redirect to new request 1 cycle.
// Backpressure: no request issued unless the queue will have room; id outputs held while stalled.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [5:0]  id_opcode
);

    localparam logic [2:0] DEPTH_W = 3'(DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [1:0]   q_count;
    fetch_entry_t q_head;
    fetch_entry_t q_push_dat;
    logic         pop;
    logic         push;
    logic         resp_vld;
    logic         issue;
    logic [2:0]   occ_next;

    assign id_valid  = (q_count != 2'd0);
    assign id_instr  = q_head.instr;
    assign id_pc     = q_head.pc;
    assign id_opcode = q_head.instr[31:26];

    assign pop      = id_valid & id_ready;
    assign resp_vld = imem_rvalid & (state_q != ST_FETCH);
    assign push     = imem_rvalid & (state_q == ST_WAIT) & ~redirect_valid;
    assign occ_next = {1'b0, q_count} + {2'b00, push} - {2'b00, pop};
    assign issue    = ~redirect_valid & ((state_q == ST_FETCH) | resp_vld) & (occ_next < DEPTH_W);

    // Request must read as idle while reset is held, even though the state regs already look like FETCH.
    assign imem_req  = issue & rst_n;
    assign imem_addr = fetch_pc_q;

    // In WAIT the outstanding address is always the one just before fetch_pc.
    assign q_push_dat.pc    = fetch_pc_q - 32'd4;
    assign q_push_dat.instr = imem_rdata;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            state_d    = ((state_q != ST_FETCH) && !imem_rvalid) ? ST_DROP : ST_FETCH;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
            case (state_q)
                ST_FETCH: if (issue) state_d = ST_WAIT;
                ST_WAIT,
                ST_DROP:  if (imem_rvalid) state_d = issue ? ST_WAIT : ST_FETCH;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (push),
        .push_dat (q_push_dat),
        .pop      (pop),
        .count    (q_count),
        .head_dat (q_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + random bench for fetch_unit against a stream-level model:
// decode must see consecutive word addresses from the last redirect, each carrying memory's word.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [5:0]  id_opcode;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // memory model: one request in flight, fixed or random latency
    bit          mem_busy;
    bit          mem_stale;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          lat      = 1;
    bit          lat_rand = 1'b0;

    // decode-stream model
    logic [31:0] exp_req_pc;
    logic [31:0] exp_id_pc;
    int          occ;
    int          hs_count;
    bit          hold_vld;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mem_busy   = 1'b0;
        mem_stale  = 1'b0;
        mem_cnt    = 0;
        exp_req_pc = 32'h0;
        exp_id_pc  = 32'h0;
        occ        = 0;
        hs_count   = 0;
        hold_vld   = 1'b0;
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt,
                        output bit o_req, output logic [31:0] o_addr,
                        output bit o_vld, output logic [31:0] o_pc);
        logic [31:0] w;
        bit          exp_req;
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (mem_busy && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        o_req  = imem_req;
        o_addr = imem_addr;
        o_vld  = id_valid;
        o_pc   = id_pc;

        chk("id_valid", {31'b0, id_valid}, {31'b0, occ > 0});
        if (hold_vld) begin
            chk("hold_instr", id_instr, hold_instr);
            chk("hold_pc", id_pc, hold_pc);
        end
        if (id_valid && id_ready) begin
            w = mem_word(exp_id_pc);
            chk("id_pc", id_pc, exp_id_pc);
            chk("id_instr", id_instr, w);
            chk("id_opcode", {26'b0, id_opcode}, {26'b0, w[31:26]});
            exp_id_pc = exp_id_pc + 32'd4;
            hs_count++;
            occ--;
        end
        if (imem_rvalid) begin
            mem_busy = 1'b0;
            if (!mem_stale && !redir) occ++;
        end
        exp_req = !redir && !mem_busy && (occ < 2);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (imem_req) begin
            chk("imem_addr", imem_addr, exp_req_pc);
            mem_busy   = 1'b1;
            mem_stale  = 1'b0;
            mem_addr   = imem_addr;
            mem_cnt    = (lat_rand ? int'($urandom_range(1, 3)) : lat) - 1;
            exp_req_pc = exp_req_pc + 32'd4;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (redir) begin
            exp_id_pc  = tgt & ~32'd3;
            exp_req_pc = tgt & ~32'd3;
            occ        = 0;
            if (mem_busy) mem_stale = 1'b1;
        end
        hold_vld   = id_valid && !id_ready && !redir;
        hold_instr = id_instr;
        hold_pc    = id_pc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit          r;
        bit          v;
        logic [31:0] a;
        logic [31:0] p;
        int          n;
        bit          saw_fffc;
        bit          saw_wrap;

        rst_n          = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        model_reset();
        #1;
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_opcode", {26'b0, id_opcode}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back stream after reset
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0, r, a, v, p);
            if (i < 4) begin
                chk("b2b_req", {31'b0, r}, 32'h1);
                chk("b2b_addr", a, 32'(i * 4));
            end
            if (i == 1) chk("first_vld_latency", {31'b0, v}, 32'h0);
            if (i >= 2) begin
                chk("b2b_vld", {31'b0, v}, 32'h1);
                chk("b2b_pc", p, 32'((i - 2) * 4));
            end
        end

        // decode stall fills the queue, then drains in order
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, r, a, v, p);
        chk("stall_req_low", {31'b0, r}, 32'h0);
        chk("stall_vld", {31'b0, v}, 32'h1);
        n = hs_count;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, r, a, v, p);
        chk("drain_count", 32'(hs_count - n), 32'd8);

        // redirect while a slow response is outstanding
        lat = 3;
        n = 0;
        do begin
            step(1'b1, 1'b0, 32'h0, r, a, v, p);
            n++;
        end while (!r && n < 10);
        chk("slow_req_seen", {31'b0, r}, 32'h1);
        step(1'b1, 1'b1, 32'h40, r, a, v, p);
        lat = 1;
        step(1'b1, 1'b0, 32'h0, r, a, v, p);
        chk("drop_vld_low", {31'b0, v}, 32'h0);
        chk("drop_no_req", {31'b0, r}, 32'h0);
        n = 0;
        do begin
            step(1'b1, 1'b0, 32'h0, r, a, v, p);
            n++;
        end while (!v && n < 20);
        chk("after_drop_pc", p, 32'h40);

        // redirect coinciding with response and handshake
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, r, a, v, p);
        step(1'b1, 1'b1, 32'h40, r, a, v, p);
        chk("coincide_vld", {31'b0, v}, 32'h1);
        step(1'b1, 1'b0, 32'h0, r, a, v, p);
        chk("coincide_req", {31'b0, r}, 32'h1);
        chk("coincide_addr", a, 32'h40);
        chk("coincide_vld_low", {31'b0, v}, 32'h0);

        // unaligned target and address wrap
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, r, a, v, p);
        step(1'b1, 1'b1, 32'h43, r, a, v, p);
        step(1'b1, 1'b0, 32'h0, r, a, v, p);
        chk("unaligned_addr", a, 32'h40);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, r, a, v, p);
        step(1'b1, 1'b1, 32'hFFFF_FFF8, r, a, v, p);
        saw_fffc = 1'b0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32'h0, r, a, v, p);
            if (r && a == 32'hFFFF_FFFC) saw_fffc = 1'b1;
            if (r && a == 32'h0 && saw_fffc) saw_wrap = 1'b1;
        end
        chk("pc_wrap", {31'b0, saw_wrap}, 32'h1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, r, a, v, p);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("arst_imem_addr", imem_addr, 32'h0);
        chk("arst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("arst_id_instr", id_instr, 32'h0);
        chk("arst_id_pc", id_pc, 32'h0);
        chk("arst_id_opcode", {26'b0, id_opcode}, 32'h0);
        imem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h0, r, a, v, p);
        chk("restart_req", {31'b0, r}, 32'h1);
        chk("restart_addr", a, 32'h0);
        n = 0;
        do begin
            step(1'b1, 1'b0, 32'h0, r, a, v, p);
            n++;
        end while (!v && n < 10);
        chk("restart_pc", p, 32'h0);

        // random latency, stalls and redirects
        lat_rand = 1'b1;
        n = hs_count;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), $urandom, r, a, v, p);
        end
        checks++;
        assert (hs_count - n > 50)
        else begin
            failures++;
            $error("FAIL random_progress observed=%0d expected=>50", hs_count - n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
